// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between the IFU and the LSU.
// One transaction is in flight at a time. The request payload is registered
// before it goes downstream, and the response is steered back to its owner.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin arbitration
// instead of the default fixed LSU-over-IFU priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_W-1:0]     ifu_resp_data,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_resp_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_data,

    output logic                  busy,
    output logic                  resp_err
);

    localparam int unsigned MASK_W = DATA_W / 8;

    // Requester identity, used for owner and last_grant
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic   owner;
    logic   grant_ifu;
    logic   grant_lsu;
    logic   handshake;
    logic   resp_take;
    logic   resp_stray;

`ifdef ARB_ROUND_ROBIN_EN
    logic   last_grant;

    // Round-robin pick: on contention the requester not granted last time wins
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (ifu_req_valid && lsu_req_valid) begin
            if (last_grant == OWN_LSU) begin
                grant_ifu = 1'b1;
            end else begin
                grant_lsu = 1'b1;
            end
        end else begin
            grant_ifu = ifu_req_valid;
            grant_lsu = lsu_req_valid;
        end
    end

    // Remember who won the most recent handshake; starts as LSU so IFU wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= OWN_LSU;
        end else if (handshake) begin
            last_grant <= lsu_req_ready;
        end
    end
`else
    // Fixed priority pick: LSU always beats IFU
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        grant_lsu = lsu_req_valid;
        grant_ifu = ifu_req_valid && !lsu_req_valid;
    end
`endif

    assign handshake  = ifu_req_ready || lsu_req_ready;
    assign resp_take  = (state == ST_WAIT) && mem_resp_valid;
    assign resp_stray = (state != ST_WAIT) && mem_resp_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and request readies; readies only ever open in IDLE
    always_comb begin
        state_nxt     = state;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                ifu_req_ready = grant_ifu && !rst;
                lsu_req_ready = grant_lsu && !rst;
                if (grant_ifu || grant_lsu) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status flags follow the state, registered alongside it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            mem_req_valid <= (state_nxt == ST_REQ);
            busy          <= (state_nxt != ST_IDLE);
        end
    end

    // Capture the granted requester's payload and ownership on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            owner         <= OWN_IFU;
        end else if (handshake) begin
            if (lsu_req_ready) begin
                mem_req_addr  <= lsu_req_addr;
                mem_req_wen   <= lsu_req_wen;
                mem_req_wdata <= lsu_req_wdata;
                mem_req_wmask <= lsu_req_wmask;
                owner         <= OWN_LSU;
            end else begin
                mem_req_addr  <= ifu_req_addr;
                mem_req_wen   <= 1'b0;
                mem_req_wdata <= '0;
                mem_req_wmask <= MASK_W'(0);
                owner         <= OWN_IFU;
            end
        end
    end

    // Route the captured response to its owner as a one-cycle pulse; data is zero otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifu_resp_valid <= 1'b0;
            ifu_resp_data  <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_data  <= '0;
        end else begin
            ifu_resp_valid <= 1'b0;
            ifu_resp_data  <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_data  <= '0;
            if (resp_take) begin
                if (owner == OWN_LSU) begin
                    lsu_resp_valid <= 1'b1;
                    lsu_resp_data  <= mem_resp_data;
                end else begin
                    ifu_resp_valid <= 1'b1;
                    ifu_resp_data  <= mem_resp_data;
                end
            end
        end
    end

    // Sticky flag for responses arriving when none is expected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_err <= 1'b0;
        end else if (resp_stray) begin
            resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a readiness vector table, directed
// corner-case sequences, and a randomized run against a transaction-level model.
// Honours ARB_ROUND_ROBIN_EN for arbitration expectations.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [63:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic [63:0] ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready;
    logic [63:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [63:0] lsu_req_wdata;
    logic [7:0]  lsu_req_wmask;
    logic        lsu_resp_valid;
    logic [63:0] lsu_resp_data;
    logic        mem_req_valid, mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        busy, resp_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_resp_data(ifu_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic ifu_v;
        logic lsu_v;
        logic exp_ifu_rdy;
        logic exp_lsu_rdy;
    } vec_t;

    vec_t vecs [4];

    // Transaction-level reference model state
    bit          m_active, m_acc, m_owner_lsu, m_err, m_last_lsu;
    logic [63:0] m_addr, m_wdata;
    bit          m_wen;
    logic [7:0]  m_wmask;
    bit          m_ifu_pulse, m_lsu_pulse;
    logic [63:0] m_resp_data;
    bit          ifu_pend, lsu_pend;

    initial begin
        rst = 1'b1;
        ifu_req_valid = 0; ifu_req_addr = 0;
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0;
        lsu_req_wdata = 0; lsu_req_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
        chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
        chk("rst_mem_req_addr", mem_req_addr, 0);
        rst = 1'b0;
        tick();

        // ---- IDLE grant table (no clock edge consumed) ----
        vecs[0] = '{ifu_v: 1'b0, lsu_v: 1'b0, exp_ifu_rdy: 1'b0, exp_lsu_rdy: 1'b0};
        vecs[1] = '{ifu_v: 1'b1, lsu_v: 1'b0, exp_ifu_rdy: 1'b1, exp_lsu_rdy: 1'b0};
        vecs[2] = '{ifu_v: 1'b0, lsu_v: 1'b1, exp_ifu_rdy: 1'b0, exp_lsu_rdy: 1'b1};
        vecs[3] = '{ifu_v: 1'b1, lsu_v: 1'b1, exp_ifu_rdy: RR, exp_lsu_rdy: !RR};
        for (int i = 0; i < 4; i++) begin
            ifu_req_valid = vecs[i].ifu_v;
            lsu_req_valid = vecs[i].lsu_v;
            #1;
            chk($sformatf("tbl%0d_ifu_rdy", i), ifu_req_ready, vecs[i].exp_ifu_rdy);
            chk($sformatf("tbl%0d_lsu_rdy", i), lsu_req_ready, vecs[i].exp_lsu_rdy);
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        tick();

        // ---- single fetch, zero-wait memory ----
        ifu_req_valid = 1; ifu_req_addr = 64'h8000_0000; mem_req_ready = 1;
        #1;
        chk("fetch_ifu_rdy", ifu_req_ready, 1);
        chk("fetch_lsu_rdy", lsu_req_ready, 0);
        tick();
        ifu_req_valid = 0; ifu_req_addr = 64'h1234;
        chk("fetch_mem_valid", mem_req_valid, 1);
        chk("fetch_mem_addr", mem_req_addr, 64'h8000_0000);
        chk("fetch_mem_wen", mem_req_wen, 0);
        chk("fetch_mem_wmask", mem_req_wmask, 0);
        chk("fetch_busy", busy, 1);
        tick();
        chk("fetch_wait_mem_valid", mem_req_valid, 0);
        chk("fetch_wait_busy", busy, 1);
        mem_resp_valid = 1; mem_resp_data = 64'h13;
        tick();
        mem_resp_valid = 0; mem_resp_data = 0;
        chk("fetch_ifu_resp_valid", ifu_resp_valid, 1);
        chk("fetch_ifu_resp_data", ifu_resp_data, 64'h13);
        chk("fetch_lsu_resp_valid", lsu_resp_valid, 0);
        chk("fetch_idle_busy", busy, 0);
        tick();
        chk("fetch_pulse_end", ifu_resp_valid, 0);
        chk("fetch_data_zero", ifu_resp_data, 0);

        // ---- store passthrough with downstream stall ----
        mem_req_ready = 0;
        lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 64'h8000_1000;
        lsu_req_wdata = 64'hDEAD_BEEF; lsu_req_wmask = 8'h0F;
        #1;
        chk("store_lsu_rdy", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 0; lsu_req_addr = '1; lsu_req_wdata = 0; lsu_req_wmask = '1; lsu_req_wen = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("store_stall%0d_valid", i), mem_req_valid, 1);
            chk($sformatf("store_stall%0d_addr", i), mem_req_addr, 64'h8000_1000);
            chk($sformatf("store_stall%0d_wen", i), mem_req_wen, 1);
            chk($sformatf("store_stall%0d_wdata", i), mem_req_wdata, 64'hDEAD_BEEF);
            chk($sformatf("store_stall%0d_wmask", i), mem_req_wmask, 8'h0F);
            tick();
        end
        mem_req_ready = 1;
        chk("store_accept_valid", mem_req_valid, 1);
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 64'h55;
        tick();
        mem_resp_valid = 0; mem_resp_data = 0;
        chk("store_lsu_resp_valid", lsu_resp_valid, 1);
        chk("store_lsu_resp_data", lsu_resp_data, 64'h55);
        chk("store_ifu_resp_valid", ifu_resp_valid, 0);
        tick();
        chk("store_pulse_end", lsu_resp_valid, 0);

        // ---- contention: both valid for 4 transactions ----
        mem_req_ready = 1;
        ifu_req_valid = 1; ifu_req_addr = 64'hA000;
        lsu_req_valid = 1; lsu_req_addr = 64'hB000; lsu_req_wen = 0;
        for (int i = 0; i < 4; i++) begin
            bit exp_lsu;
            exp_lsu = RR ? (i % 2 == 1) : 1'b1;
            #1;
            chk($sformatf("cont%0d_ifu_rdy", i), ifu_req_ready, !exp_lsu);
            chk($sformatf("cont%0d_lsu_rdy", i), lsu_req_ready, exp_lsu);
            tick();
            tick();
            mem_resp_valid = 1; mem_resp_data = 64'h100 + 64'(i);
            tick();
            mem_resp_valid = 0;
            chk($sformatf("cont%0d_lsu_pulse", i), lsu_resp_valid, exp_lsu);
            chk($sformatf("cont%0d_ifu_pulse", i), ifu_resp_valid, !exp_lsu);
            chk($sformatf("cont%0d_data", i), exp_lsu ? lsu_resp_data : ifu_resp_data, 64'h100 + 64'(i));
        end
        ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 0;
        tick();

        // ---- busy blocking: LSU waits out an IFU transaction ----
        ifu_req_valid = 1; ifu_req_addr = 64'h2000;
        #1;
        chk("blk_ifu_rdy", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 0; lsu_req_valid = 1; lsu_req_addr = 64'h3000;
        #1;
        chk("blk_req0_lsu_rdy", lsu_req_ready, 0);
        tick();
        #1;
        chk("blk_req1_lsu_rdy", lsu_req_ready, 0);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        #1;
        chk("blk_wait_lsu_rdy", lsu_req_ready, 0);
        mem_resp_valid = 1; mem_resp_data = 64'h77;
        tick();
        mem_resp_valid = 0;
        #1;
        chk("blk_ifu_pulse", ifu_resp_valid, 1);
        chk("blk_lsu_granted", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 0;
        chk("blk_lsu_mem_valid", mem_req_valid, 1);
        chk("blk_lsu_mem_addr", mem_req_addr, 64'h3000);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 64'h88;
        tick();
        mem_resp_valid = 0;
        chk("blk_lsu_pulse", lsu_resp_valid, 1);
        chk("blk_lsu_data", lsu_resp_data, 64'h88);
        tick();

        // ---- stray response in IDLE ----
        chk("stray_err_before", resp_err, 0);
        mem_resp_valid = 1; mem_resp_data = 64'h66;
        tick();
        mem_resp_valid = 0;
        chk("stray_err_set", resp_err, 1);
        chk("stray_no_ifu", ifu_resp_valid, 0);
        chk("stray_no_lsu", lsu_resp_valid, 0);
        chk("stray_busy", busy, 0);
        repeat (3) tick();
        chk("stray_err_sticky", resp_err, 1);

        // ---- reset while in WAIT ----
        ifu_req_valid = 1; ifu_req_addr = 64'h4000; mem_req_ready = 1;
        tick();
        ifu_req_valid = 0;
        tick();
        mem_req_ready = 0;
        chk("rstw_busy_before", busy, 1);
        #2;
        rst = 1;
        #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_mem_valid", mem_req_valid, 0);
        chk("rstw_resp_err", resp_err, 0);
        tick();
        rst = 0;
        tick();
        mem_resp_valid = 1; mem_resp_data = 64'h99;
        tick();
        mem_resp_valid = 0;
        chk("rstw_no_ifu", ifu_resp_valid, 0);
        chk("rstw_no_lsu", lsu_resp_valid, 0);
        chk("rstw_late_err", resp_err, 1);

        // ---- randomized run against the transaction model ----
        rst = 1;
        tick();
        rst = 0;
        tick();
        m_active = 0; m_acc = 0; m_owner_lsu = 0; m_err = 0; m_last_lsu = 1;
        m_addr = 0; m_wdata = 0; m_wen = 0; m_wmask = 0;
        m_ifu_pulse = 0; m_lsu_pulse = 0; m_resp_data = 0;
        ifu_pend = 0; lsu_pend = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit exp_ifu_rdy, exp_lsu_rdy, hs_ifu, hs_lsu, resp_ok;

            chk("rnd_busy", busy, m_active);
            chk("rnd_mem_valid", mem_req_valid, m_active && !m_acc);
            if (m_active && !m_acc) begin
                chk("rnd_mem_addr", mem_req_addr, m_addr);
                chk("rnd_mem_wen", mem_req_wen, m_wen);
                chk("rnd_mem_wmask", mem_req_wmask, m_wmask);
                if (m_owner_lsu) chk("rnd_mem_wdata", mem_req_wdata, m_wdata);
            end
            chk("rnd_ifu_resp_valid", ifu_resp_valid, m_ifu_pulse);
            chk("rnd_ifu_resp_data", ifu_resp_data, m_ifu_pulse ? m_resp_data : 64'h0);
            chk("rnd_lsu_resp_valid", lsu_resp_valid, m_lsu_pulse);
            chk("rnd_lsu_resp_data", lsu_resp_data, m_lsu_pulse ? m_resp_data : 64'h0);
            chk("rnd_resp_err", resp_err, m_err);

            // Well-behaved requesters: hold valid and payload until accepted
            if (!ifu_pend && ($urandom % 3 == 0)) begin
                ifu_pend = 1;
                ifu_req_addr = {$urandom, $urandom};
            end
            if (!lsu_pend && ($urandom % 3 == 0)) begin
                lsu_pend = 1;
                lsu_req_addr  = {$urandom, $urandom};
                lsu_req_wen   = 1'($urandom);
                lsu_req_wdata = {$urandom, $urandom};
                lsu_req_wmask = 8'($urandom);
            end
            ifu_req_valid = ifu_pend;
            lsu_req_valid = lsu_pend;
            mem_req_ready = 1'($urandom);
            resp_ok = m_active && m_acc;
            mem_resp_valid = resp_ok ? ($urandom % 2 == 0) : ($urandom % 16 == 0);
            mem_resp_data = {$urandom, $urandom};
            #1;

            exp_ifu_rdy = 0; exp_lsu_rdy = 0;
            if (!m_active) begin
                if (ifu_pend && lsu_pend) begin
                    if (RR) begin
                        exp_lsu_rdy = !m_last_lsu;
                        exp_ifu_rdy = m_last_lsu;
                    end else begin
                        exp_lsu_rdy = 1;
                    end
                end else begin
                    exp_ifu_rdy = ifu_pend;
                    exp_lsu_rdy = lsu_pend;
                end
            end
            chk("rnd_ifu_rdy", ifu_req_ready, exp_ifu_rdy);
            chk("rnd_lsu_rdy", lsu_req_ready, exp_lsu_rdy);
            hs_ifu = exp_ifu_rdy;
            hs_lsu = exp_lsu_rdy;

            m_ifu_pulse = 0; m_lsu_pulse = 0; m_resp_data = 0;
            if (resp_ok && mem_resp_valid) begin
                if (m_owner_lsu) m_lsu_pulse = 1; else m_ifu_pulse = 1;
                m_resp_data = mem_resp_data;
                m_active = 0;
            end else if (mem_resp_valid) begin
                m_err = 1;
            end
            if (m_active && !m_acc && mem_req_ready) m_acc = 1;
            if (hs_ifu || hs_lsu) begin
                m_active = 1; m_acc = 0;
                m_owner_lsu = hs_lsu;
                m_last_lsu = hs_lsu;
                m_addr  = hs_lsu ? lsu_req_addr : ifu_req_addr;
                m_wen   = hs_lsu ? lsu_req_wen : 1'b0;
                m_wdata = lsu_req_wdata;
                m_wmask = hs_lsu ? lsu_req_wmask : 8'h0;
                if (hs_lsu) lsu_pend = 0; else ifu_pend = 0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
